// File: rtl/ds18b20_responder_pkg.sv
// Shared definitions for the DS18B20 1-Wire responder: command bytes, slot timing,
// FSM states and the scratchpad byte map.
package ds18b20_responder_pkg;

  localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
  localparam logic [7:0] CMD_CONVERT  = 8'h44;
  localparam logic [7:0] CMD_READ_SCR = 8'hBE;

  localparam int RST_US       = 480;
  localparam int PRES_WAIT_US = 30;
  localparam int PRES_US      = 120;
  localparam int SLOT_US      = 30;

  typedef enum logic [2:0] {
    IDLE,
    RST_WAIT,
    PRES_WAIT,
    PRES_DRV,
    ROM_CMD,
    FUNC_CMD,
    CONVERT,
    TX_SCR
  } dsState_e;

  // Byte 8 carries the CRC; indices past the scratchpad read as a released bus.
  function automatic logic [7:0] scratchByte(input logic [3:0] idx,
                                             input logic [11:0] temp,
                                             input logic [7:0] crc);
    logic [7:0] b;
    case (idx)
      4'd0:    b = temp[7:0];
      4'd1:    b = {{4{temp[11]}}, temp[11:8]};
      4'd2:    b = 8'h4B;
      4'd3:    b = 8'h46;
      4'd4:    b = 8'h7F;
      4'd5:    b = 8'hFF;
      4'd6:    b = 8'h0C;
      4'd7:    b = 8'h10;
      4'd8:    b = crc;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ds18b20_responder_crc8.sv
// Bit-serial Dallas CRC-8 (x^8+x^5+x^4+1, reflected, init 0x00).
// Only compiled when DS_CRC_EN is defined.
`ifdef DS_CRC_EN
module onewire_crc8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic       data_in,
  output logic [7:0] crc_out
);

  logic [7:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = crc_q[0] ^ data_in;
    crc_d = crc_q;
    if (clear)
      crc_d = 8'h00;
    else if (enable)
      crc_d = {1'b0, crc_q[7:1]} ^ (fb ? 8'h8C : 8'h00);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) crc_q <= 8'h00;
    else      crc_q <= crc_d;
  end

  assign crc_out = crc_q;

endmodule
`endif

// File: rtl/ds18b20_responder.sv
// DS18B20 emulator on a 1-Wire bus: presence, Skip ROM, Convert T, Read Scratchpad.
// Define DS_CRC_EN to send a real CRC-8 in scratchpad byte 8 (0x00 otherwise).
module ds18b20_responder
  import ds18b20_responder_pkg::*;
#(
  parameter int CLK_PER_US = 1,
  parameter int CONV_US    = 750000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dq_in,
  output logic        dq_oe,
  input  logic [11:0] temp_in,
  output logic        busy,
  output logic [7:0]  cmd_code,
  output logic        cmd_err
);

  logic        dqMeta_q, dqSync_q, dqPrev_q;
  logic [15:0] psc_q;
  logic [9:0]  lowCnt_q;
  logic        tick, fallEdge, riseEdge, slotFall;

  dsState_e    state_q, state_d;
  logic [7:0]  tmr_q, tmr_d;
  logic        sampPend_q, sampPend_d;
  logic        dq_oe_q, dq_oe_d;
  logic [7:0]  rx_q, rx_d, rxByte;
  logic [2:0]  bitCnt_q, bitCnt_d;
  logic [6:0]  txIdx_q, txIdx_d;
  logic [11:0] temp_q, temp_d;
  logic        busy_q, busy_d;
  logic [31:0] convCnt_q, convCnt_d;
  logic [7:0]  cmd_code_q, cmd_code_d;
  logic        cmd_err_q, cmd_err_d;
  logic [7:0]  txByte, crcVal;
  logic        txBit, crcClr, crcEn, crcBit;

  assign tick     = (psc_q == 16'(CLK_PER_US - 1));
  assign fallEdge = dqPrev_q & ~dqSync_q;
  assign riseEdge = ~dqPrev_q & dqSync_q;
  assign slotFall = fallEdge & ~dq_oe_q;

  // The low-time counter ignores lows we cause ourselves, so presence and read-0 drives never look like a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dqMeta_q <= 1'b1;
      dqSync_q <= 1'b1;
      dqPrev_q <= 1'b1;
      psc_q    <= '0;
      lowCnt_q <= '0;
    end else begin
      dqMeta_q <= dq_in;
      dqSync_q <= dqMeta_q;
      dqPrev_q <= dqSync_q;
      psc_q    <= tick ? 16'd0 : psc_q + 16'd1;
      if (dq_oe_q || dqSync_q)
        lowCnt_q <= '0;
      else if (tick && lowCnt_q != 10'(RST_US))
        lowCnt_q <= lowCnt_q + 10'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    sampPend_d = sampPend_q;
    dq_oe_d    = dq_oe_q;
    rx_d       = rx_q;
    bitCnt_d   = bitCnt_q;
    txIdx_d    = txIdx_q;
    temp_d     = temp_q;
    busy_d     = busy_q;
    convCnt_d  = convCnt_q;
    cmd_code_d = cmd_code_q;
    cmd_err_d  = 1'b0;
    crcClr     = 1'b0;
    crcEn      = 1'b0;
    crcBit     = 1'b0;
    rxByte     = {dqSync_q, rx_q[7:1]};
    txByte     = scratchByte(txIdx_q[6:3], temp_q, crcVal);
    txBit      = txByte[txIdx_q[2:0]];

    // Conversion runs independently of the bus state so a reset pulse cannot cancel it.
    if (busy_q && tick) begin
      convCnt_d = convCnt_q - 32'd1;
      if (convCnt_q == 32'd1) busy_d = 1'b0;
    end

    if (dq_oe_q && state_q != PRES_DRV && tick) begin
      if (tmr_q == 8'(SLOT_US - 1)) begin
        dq_oe_d = 1'b0;
        tmr_d   = '0;
      end else begin
        tmr_d = tmr_q + 8'd1;
      end
    end

    case (state_q)
      RST_WAIT:
        if (riseEdge) begin
          state_d = PRES_WAIT;
          tmr_d   = '0;
        end
      PRES_WAIT:
        if (tick) begin
          if (tmr_q == 8'(PRES_WAIT_US - 1)) begin
            state_d = PRES_DRV;
            tmr_d   = '0;
            dq_oe_d = 1'b1;
          end else begin
            tmr_d = tmr_q + 8'd1;
          end
        end
      PRES_DRV:
        if (tick) begin
          if (tmr_q == 8'(PRES_US - 1)) begin
            state_d  = ROM_CMD;
            tmr_d    = '0;
            dq_oe_d  = 1'b0;
            bitCnt_d = '0;
          end else begin
            tmr_d = tmr_q + 8'd1;
          end
        end
      ROM_CMD, FUNC_CMD:
        if (sampPend_q) begin
          if (tick) begin
            if (tmr_q == 8'(SLOT_US - 1)) begin
              sampPend_d = 1'b0;
              tmr_d      = '0;
              rx_d       = rxByte;
              bitCnt_d   = bitCnt_q + 3'd1;
              if (bitCnt_q == 3'd7) begin
                cmd_code_d = rxByte;
                if (state_q == ROM_CMD) begin
                  if (rxByte == CMD_SKIP_ROM) begin
                    state_d = FUNC_CMD;
                  end else begin
                    cmd_err_d = 1'b1;
                    state_d   = IDLE;
                  end
                end else if (rxByte == CMD_CONVERT) begin
                  state_d   = CONVERT;
                  busy_d    = 1'b1;
                  convCnt_d = 32'(CONV_US);
                  temp_d    = temp_in;
                end else if (rxByte == CMD_READ_SCR) begin
                  state_d = TX_SCR;
                  txIdx_d = '0;
                  crcClr  = 1'b1;
                end else begin
                  cmd_err_d = 1'b1;
                  state_d   = IDLE;
                end
              end
            end else begin
              tmr_d = tmr_q + 8'd1;
            end
          end
        end else if (slotFall) begin
          sampPend_d = 1'b1;
          tmr_d      = '0;
        end
      CONVERT:
        if (slotFall && busy_q) begin
          dq_oe_d = 1'b1;
          tmr_d   = '0;
        end
      TX_SCR:
        if (slotFall) begin
          if (!txBit) begin
            dq_oe_d = 1'b1;
            tmr_d   = '0;
          end
          crcEn  = (txIdx_q < 7'd64);
          crcBit = txBit;
          if (txIdx_q == 7'd71) state_d = IDLE;
          else                  txIdx_d = txIdx_q + 7'd1;
        end
      default: ;
    endcase

    if (!dqSync_q && lowCnt_q == 10'(RST_US)) begin
      state_d    = RST_WAIT;
      dq_oe_d    = 1'b0;
      sampPend_d = 1'b0;
      tmr_d      = '0;
      bitCnt_d   = '0;
      txIdx_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      sampPend_q <= 1'b0;
      dq_oe_q    <= 1'b0;
      rx_q       <= '0;
      bitCnt_q   <= '0;
      txIdx_q    <= '0;
      temp_q     <= 12'h550;
      busy_q     <= 1'b0;
      convCnt_q  <= '0;
      cmd_code_q <= 8'h00;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      sampPend_q <= sampPend_d;
      dq_oe_q    <= dq_oe_d;
      rx_q       <= rx_d;
      bitCnt_q   <= bitCnt_d;
      txIdx_q    <= txIdx_d;
      temp_q     <= temp_d;
      busy_q     <= busy_d;
      convCnt_q  <= convCnt_d;
      cmd_code_q <= cmd_code_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

`ifdef DS_CRC_EN
  onewire_crc8 uCrc (
    .clk     (clk),
    .rst     (rst),
    .clear   (crcClr),
    .enable  (crcEn),
    .data_in (crcBit),
    .crc_out (crcVal)
  );
`else
  logic unusedCrc;
  assign unusedCrc = crcClr ^ crcEn ^ crcBit;
  assign crcVal    = 8'h00;
`endif

  assign dq_oe    = dq_oe_q;
  assign busy     = busy_q;
  assign cmd_code = cmd_code_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_ds18b20_responder.sv
// Directed bench for ds18b20_responder acting as a 1-Wire master at 1 clk per us.
// Works with or without DS_CRC_EN; the expected byte 8 follows the same macro.
`timescale 1ns/1ps
module tb_ds18b20_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        masterLow;
  logic        dqLine;
  logic        dq_oe;
  logic [11:0] temp_in;
  logic        busy;
  logic [7:0]  cmd_code;
  logic        cmd_err;

  int checkCount = 0;
  int passCount  = 0;
  int errPulses  = 0;
  int oeCycles   = 0;

  // Open-drain bus: anyone pulling low wins, otherwise the pull-up holds it high.
  assign dqLine = ~(masterLow | dq_oe);

  always #5 clk = ~clk;

  ds18b20_responder #(.CLK_PER_US(1), .CONV_US(100)) dut (
    .clk      (clk),
    .rst      (rst),
    .dq_in    (dqLine),
    .dq_oe    (dq_oe),
    .temp_in  (temp_in),
    .busy     (busy),
    .cmd_code (cmd_code),
    .cmd_err  (cmd_err)
  );

  // Counts error pulses and responder drive cycles for the bad-command case.
  always @(negedge clk) begin
    if (cmd_err === 1'b1) errPulses++;
    if (dq_oe === 1'b1) oeCycles++;
  end

  // Global bound so a stuck run still ends with a reported failure.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic waitUs(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds the bus low for lowUs then releases it for highUs.
  task automatic applyStimulus(input int lowUs, input int highUs);
    masterLow = 1'b1;
    waitUs(lowUs);
    masterLow = 1'b0;
    waitUs(highUs);
  endtask

  task automatic doReset(input int lowUs);
    masterLow = 1'b1;
    waitUs(lowUs);
    masterLow = 1'b0;
    waitUs(25);
    checkOutput("pres_early", dq_oe, 0);
    waitUs(15);
    checkOutput("pres_on", dq_oe, 1);
    waitUs(105);
    checkOutput("pres_hold", dq_oe, 1);
    waitUs(20);
    checkOutput("pres_off", dq_oe, 0);
    waitUs(60);
  endtask

  task automatic writeByte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) applyStimulus(5, 65);
      else      applyStimulus(60, 10);
    end
  endtask

  task automatic readBit(output logic b);
    masterLow = 1'b1;
    waitUs(3);
    masterLow = 1'b0;
    waitUs(10);
    b = dqLine;
    waitUs(57);
  endtask

  task automatic readByte(output logic [7:0] v);
    logic b;
    for (int i = 0; i < 8; i++) begin
      readBit(b);
      v[i] = b;
    end
  endtask

  function automatic logic [7:0] crc8Model(input logic [7:0] d0, input logic [7:0] d1,
                                           input logic [7:0] d2, input logic [7:0] d3,
                                           input logic [7:0] d4, input logic [7:0] d5,
                                           input logic [7:0] d6, input logic [7:0] d7);
    logic [63:0] stream;
    logic [7:0]  c;
    stream = {d7, d6, d5, d4, d3, d2, d1, d0};
    c = 8'h00;
    for (int i = 0; i < 64; i++) begin
      if (c[0] ^ stream[i]) c = (c >> 1) ^ 8'h8C;
      else                  c = c >> 1;
    end
    return c;
  endfunction

  logic [7:0] expScr [9];
  logic [7:0] rd;
  logic       bitRd;
  int         oeBefore;

  initial begin
    rst       = 1'b0;
    masterLow = 1'b0;
    temp_in   = 12'h000;
    waitUs(3);
    checkOutput("rst_oe", dq_oe, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_code", cmd_code, 8'h00);
    checkOutput("rst_err", cmd_err, 0);
    rst = 1'b1;
    waitUs(5);

    // Reset pulse, presence, then default scratchpad (85 C).
    doReset(500);
    checkOutput("busy_idle", busy, 0);
    writeByte(8'hCC);
    writeByte(8'hBE);
    checkOutput("code_be", cmd_code, 8'hBE);
    expScr[0] = 8'h50; expScr[1] = 8'h05; expScr[2] = 8'h4B; expScr[3] = 8'h46;
    expScr[4] = 8'h7F; expScr[5] = 8'hFF; expScr[6] = 8'h0C; expScr[7] = 8'h10;
`ifdef DS_CRC_EN
    expScr[8] = crc8Model(8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10);
`else
    expScr[8] = 8'h00;
`endif
    for (int i = 0; i < 9; i++) begin
      readByte(rd);
      checkOutput($sformatf("scr_def%0d", i), rd, expScr[i]);
    end
    readByte(rd);
    checkOutput("scr_tail", rd, 8'hFF);

    // Convert T: busy reads 0, then 1 once the 100 us conversion finishes.
    temp_in = 12'h191;
    doReset(500);
    writeByte(8'hCC);
    writeByte(8'h44);
    checkOutput("code_44", cmd_code, 8'h44);
    checkOutput("busy_on", busy, 1);
    readBit(bitRd);
    checkOutput("conv_rd_busy", bitRd, 0);
    checkOutput("busy_off", busy, 0);
    readBit(bitRd);
    checkOutput("conv_rd_done", bitRd, 1);
    temp_in = 12'h7FF;
    doReset(500);
    writeByte(8'hCC);
    writeByte(8'hBE);
    readByte(rd);
    checkOutput("t191_b0", rd, 8'h91);
    readByte(rd);
    checkOutput("t191_b1", rd, 8'h01);

    // Negative temperature sign-extends into byte 1.
    temp_in = 12'hFF5;
    doReset(500);
    writeByte(8'hCC);
    writeByte(8'h44);
    waitUs(150);
    temp_in = 12'h000;
    doReset(500);
    writeByte(8'hCC);
    writeByte(8'hBE);
    readByte(rd);
    checkOutput("tneg_b0", rd, 8'hF5);
    readByte(rd);
    checkOutput("tneg_b1", rd, 8'hFF);

    // Unsupported ROM command.
    checkOutput("no_err_yet", errPulses, 0);
    doReset(500);
    writeByte(8'hA5);
    checkOutput("err_pulse", errPulses, 1);
    checkOutput("code_a5", cmd_code, 8'hA5);
    oeBefore = oeCycles;
    readByte(rd);
    checkOutput("a5_bus", rd, 8'hFF);
    checkOutput("a5_no_oe", oeCycles - oeBefore, 0);

    // Long reset in the middle of a read aborts it; next read restarts at byte 0.
    doReset(500);
    writeByte(8'hCC);
    writeByte(8'hBE);
    readByte(rd);
    checkOutput("abort_b0", rd, 8'hF5);
    readByte(rd);
    checkOutput("abort_b1", rd, 8'hFF);
    readByte(rd);
    checkOutput("abort_b2", rd, 8'h4B);
    doReset(600);
    writeByte(8'hCC);
    writeByte(8'hBE);
    readByte(rd);
    checkOutput("restart_b0", rd, 8'hF5);
    readByte(rd);
    checkOutput("restart_b1", rd, 8'hFF);

    // Asynchronous reset during the presence drive releases the bus at once.
    masterLow = 1'b1;
    waitUs(500);
    masterLow = 1'b0;
    waitUs(60);
    checkOutput("mid_drive", dq_oe, 1);
    rst = 1'b0;
    #1;
    checkOutput("async_rel", dq_oe, 0);
    checkOutput("async_code", cmd_code, 8'h00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
